// File: rtl/cart_loader.sv
// Cartridge download sequencer: captures the ioctl image into the cart dpram, then pads/mirrors the rest of the window.
// Optional `CART_MIRROR_EN enables mirroring of power-of-two images; without it the unused window is filled with 0xFF.
module cart_loader #(
  parameter int          ADDR_W     = 13,
  parameter logic [7:0]  CART_INDEX = 8'd1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout,
  output logic [ADDR_W:0]   cart_size,
  output logic              cart_valid,
  output logic              core_reset
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_FILL_RD   = 3'd2;
  localparam logic [2:0] S_FILL_WAIT = 3'd3;
  localparam logic [2:0] S_FILL_WR   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [ADDR_W:0] WIN_SIZE = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state;
  logic [ADDR_W-1:0] fill_ptr;
  logic [ADDR_W:0]   size_next;
  logic [ADDR_W:0]   addr_p1;
  logic [ADDR_W-1:0] fill_mask;
  logic [ADDR_W-1:0] fill_masked;
  logic [7:0]        fill_byte;
  logic              cart_start;
  logic              in_window;
  logic              in_fill;
  logic              start_load;
  logic              pad;

  // Largest byte count seen so far; any byte beyond the window pins the size at N.
  function automatic logic [ADDR_W:0] sat_size(input logic [ADDR_W:0] cur, input logic wr,
                                               input logic in_win, input logic [ADDR_W:0] a_p1);
    if (!wr)
      return cur;
    if (!in_win)
      return WIN_SIZE;
    return (a_p1 > cur) ? a_p1 : cur;
  endfunction

  // P-1 for the smallest power of two P >= size (P = 1 when size is 0).
  function automatic logic [ADDR_W-1:0] pow2_mask(input logic [ADDR_W:0] size);
    logic [ADDR_W:0] m;
    m = (size == '0) ? '0 : size - 1'b1;
    for (int i = 0; i <= ADDR_W; i++)
      m = m | (m >> 1);
    return m[ADDR_W-1:0];
  endfunction

  assign cart_start  = ioctl_download && (ioctl_index == CART_INDEX);
  assign in_window   = (ioctl_addr >> ADDR_W) == '0;
  assign addr_p1     = {1'b0, ioctl_addr[ADDR_W-1:0]} + 1'b1;
  assign size_next   = sat_size(cart_size, (state == S_LOAD) && ioctl_wr, in_window, addr_p1);
  assign in_fill     = (state == S_FILL_RD) || (state == S_FILL_WAIT) || (state == S_FILL_WR);
  assign start_load  = cart_start && (state != S_LOAD);
  assign fill_mask   = pow2_mask(cart_size);
  assign fill_masked = fill_ptr & fill_mask;
  assign pad         = {1'b0, fill_masked} >= cart_size;

`ifdef CART_MIRROR_EN
  assign fill_byte = pad ? 8'hFF : ram_dout;
`else
  logic fill_unused;
  assign fill_unused = ^{ram_dout, pad};
  assign fill_byte   = 8'hFF;
`endif

  assign ioctl_wait = in_fill;
  assign core_reset = reset | (state != S_DONE);

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = ioctl_dout;
    ram_we   = 1'b0;
    case (state)
      S_LOAD: begin
        ram_addr = ioctl_addr[ADDR_W-1:0];
        ram_we   = ioctl_wr && in_window;
      end
      S_FILL_RD, S_FILL_WAIT: ram_addr = fill_masked;
      S_FILL_WR: begin
        ram_addr = fill_ptr;
        ram_din  = fill_byte;
        ram_we   = !cart_start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cart_size  <= '0;
      cart_valid <= 1'b0;
    end else if (start_load) begin
      state      <= S_LOAD;
      cart_size  <= '0;
      cart_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_LOAD: begin
          cart_size <= size_next;
          if (!ioctl_download) begin
            if (size_next == WIN_SIZE) begin
              state      <= S_DONE;
              cart_valid <= 1'b1;
            end else begin
              state <= S_FILL_RD;
            end
          end
        end
        S_FILL_RD:   state <= S_FILL_WAIT;
        S_FILL_WAIT: state <= S_FILL_WR;
        S_FILL_WR: begin
          if (fill_ptr == '1) begin
            state      <= S_DONE;
            cart_valid <= (cart_size != '0);
          end else begin
            state <= S_FILL_RD;
          end
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Fill pointer starts at the final image size and walks to the top of the window.
  always_ff @(posedge clk_sys) begin
    if (state == S_LOAD)
      fill_ptr <= size_next[ADDR_W-1:0];
    else if (state == S_FILL_WR)
      fill_ptr <= fill_ptr + 1'b1;
  end

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader with a 1-cycle-latency dpram model; expectations follow `CART_MIRROR_EN.
module tb_cart_loader;

  localparam int ADDR_W = 13;
  localparam int N      = 8192;

  logic              clk_sys;
  logic              reset;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] cpu_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic [7:0]        ram_dout;
  logic [ADDR_W:0]   cart_size;
  logic              cart_valid;
  logic              core_reset;

  logic [7:0] mem [0:N-1];
  int         we_cnt = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic       wait_after_start;
  logic       core_after_start;

  cart_loader #(.ADDR_W(ADDR_W), .CART_INDEX(8'd1)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .cpu_addr(cpu_addr), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .cart_size(cart_size), .cart_valid(cart_valid),
    .core_reset(core_reset)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      we_cnt <= we_cnt + 1;
    end
    ram_dout <= mem[ram_addr];
  end

  function automatic logic [7:0] pat(input int k, input logic [7:0] x);
    logic [31:0] kk;
    kk = k;
    return kk[7:0] ^ kk[15:8] ^ x;
  endfunction

  function automatic logic [7:0] exp_byte(input int a, input int size, input logic [7:0] x);
    if (a < size) return pat(a, x);
`ifdef CART_MIRROR_EN
    begin
      int p;
      p = 1;
      while (p < size) p = p * 2;
      if ((a % p) < size) return pat(a % p, x);
    end
`endif
    return 8'hFF;
  endfunction

  task automatic load_image(input int n, input logic [7:0] x, input bit fall_with_last);
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    @(negedge clk_sys);
    wait_after_start = ioctl_wait;
    core_after_start = core_reset;
    for (int k = 0; k < n; k++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(k);
      ioctl_dout = pat(k, x);
      if (fall_with_last && k == n - 1) ioctl_download = 1'b0;
      if (k == 0) begin
        #1;
        vectors++;
        if (ram_we !== 1'b1 || ram_din !== pat(0, x) || ram_addr !== 13'd0) begin
          miscompares++;
          $display("FAIL load_we_comb: we=%b din=%h addr=%0d, want we=1 din=%h addr=0",
                   ram_we, ram_din, ram_addr, pat(0, x));
        end
      end
      @(negedge clk_sys);
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
  endtask

  task automatic wait_done(output int wait_cnt, output int cycles);
    wait_cnt = 0;
    cycles   = 0;
    while (core_reset && cycles < 40000) begin
      if (ioctl_wait) wait_cnt++;
      @(negedge clk_sys);
      cycles++;
    end
    vectors++;
    if (core_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL done_timeout: core_reset=%b after %0d cycles, want 0", core_reset, cycles);
    end
  endtask

  task automatic check_mem(input string name, input int size, input logic [7:0] x,
                           input int lo, input int hi);
    int bad = 0;
    int first = -1;
    for (int a = lo; a <= hi; a++)
      if (mem[a] !== exp_byte(a, size, x)) begin
        bad++;
        if (first < 0) first = a;
      end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s: %0d bad bytes, want 0 (first at %0d: got %h want %h)",
               name, bad, first, mem[first], exp_byte(first, size, x));
    end
  endtask

  task automatic check_status(input string name, input int size, input logic valid);
    vectors++;
    if (cart_size !== 14'(size) || cart_valid !== valid || core_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: size=%0d valid=%b core_reset=%b, want size=%0d valid=%b core_reset=0",
               name, cart_size, cart_valid, core_reset, size, valid);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_sys);
    vectors++;
    if (cart_size !== '0 || cart_valid !== 1'b0 || ram_we !== 1'b0 ||
        ioctl_wait !== 1'b0 || core_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_vals: size=%0d valid=%b we=%b wait=%b core_reset=%b, want 0 0 0 0 1",
               cart_size, cart_valid, ram_we, ioctl_wait, core_reset);
    end
    reset = 1'b0;
    cpu_addr = 13'h0155;
    @(negedge clk_sys);
    vectors++;
    if (core_reset !== 1'b1 || ram_addr !== 13'h0155) begin
      miscompares++;
      $display("FAIL idle_state: core_reset=%b ram_addr=%h, want 1 0155", core_reset, ram_addr);
    end
    cpu_addr = '0;
  endtask

  task automatic test_pow2_mirror;
    int w, c;
    load_image(4096, 8'h00, 1'b0);
    wait_done(w, c);
    check_cnt("pow2_fill_cycles", w, 12288);
    check_status("pow2_status", 4096, 1'b1);
    check_mem("pow2_mem", 4096, 8'h00, 0, N - 1);
    cpu_addr = 13'h1ABC;
    #1;
    vectors++;
    if (ram_addr !== 13'h1ABC || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL done_passthru: ram_addr=%h we=%b, want 1abc 0", ram_addr, ram_we);
    end
    cpu_addr = '0;
  endtask

  task automatic test_pad;
    int w, c;
    load_image(3000, 8'h11, 1'b1);
    wait_done(w, c);
    check_cnt("pad_fill_cycles", w, 3 * (N - 3000));
    check_status("pad_status", 3000, 1'b1);
    check_mem("pad_mem", 3000, 8'h11, 0, N - 1);
  endtask

  task automatic test_oversize;
    int w, c, we0;
    we0 = we_cnt;
    load_image(10000, 8'h22, 1'b0);
    wait_done(w, c);
    check_cnt("over_done_latency", c, 1);
    check_cnt("over_wait_cycles", w, 0);
    check_cnt("over_writes", we_cnt - we0, N);
    check_status("over_status", N, 1'b1);
    check_mem("over_mem", N, 8'h22, 0, N - 1);
  endtask

  task automatic test_foreign_index;
    int we0;
    logic saw_reset;
    we0 = we_cnt;
    saw_reset = 1'b0;
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_sys);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(k);
      ioctl_dout = 8'hEE;
      #1;
      if (ram_we !== 1'b0 || core_reset !== 1'b0) saw_reset = 1'b1;
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check_cnt("foreign_writes", we_cnt - we0, 0);
    check_cnt("foreign_glitch", int'(saw_reset), 0);
    check_status("foreign_status", N, 1'b1);
  endtask

  task automatic test_abort;
    int w, c;
    load_image(3000, 8'h5A, 1'b0);
    repeat (6001) @(negedge clk_sys);
    vectors++;
    if (ioctl_wait !== 1'b1 || ram_addr !== 13'd904) begin
      miscompares++;
      $display("FAIL abort_at_5000: wait=%b ram_addr=%0d, want 1 904", ioctl_wait, ram_addr);
    end
    load_image(4096, 8'hC3, 1'b0);
    vectors++;
    if (wait_after_start !== 1'b0 || core_after_start !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_wait_drop: wait=%b core_reset=%b, want 0 1",
               wait_after_start, core_after_start);
    end
    wait_done(w, c);
    check_cnt("abort_fill_cycles", w, 12288);
    check_status("abort_status", 4096, 1'b1);
    check_mem("abort_mem", 4096, 8'hC3, 0, N - 1);
  endtask

  task automatic test_mid_reset;
    load_image(100, 8'h77, 1'b0);
    repeat (30) @(negedge clk_sys);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (ioctl_wait !== 1'b0 || core_reset !== 1'b1 || cart_size !== '0 || cart_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: wait=%b core_reset=%b size=%0d valid=%b, want 0 1 0 0",
               ioctl_wait, core_reset, cart_size, cart_valid);
    end
    check_mem("mid_reset_keep", 100, 8'h77, 0, 99);
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    cpu_addr       = '0;
    test_reset();
    test_pow2_mirror();
    test_pad();
    test_oversize();
    test_foreign_index();
    test_abort();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
